// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fifo_pkg
// Purpose  : Shared defaults and the clog2 helper for sync_fifo and fifo_mem.
// Revision : 1.0
// ============================================================================
package fifo_pkg;

    localparam int DEFAULT_DATA_W = 16;
    localparam int DEFAULT_DEPTH  = 8;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_mem.sv
`default_nettype none
// ============================================================================
// Module   : fifo_mem
// Purpose  : Simple dual-port storage array, synchronous write, async read.
// Revision : 1.0
// ============================================================================
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W,
    parameter int DEPTH  = DEFAULT_DEPTH,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_idx_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic [AW-1:0]     rd_idx_i,
    output logic [DATA_W-1:0] rd_data_o
);

    // Storage is intentionally left unreset.
    logic [DATA_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_idx_i];

endmodule : fifo_mem
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Purpose  : Parametrised single-clock FIFO with flags, count and error pulses.
//            Define FIFO_FWFT_EN for first-word-fall-through read mode.
// Revision : 1.0
// ============================================================================
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int DEPTH     = DEFAULT_DEPTH,
    parameter int AFULL_TH  = 6,
    parameter int AEMPTY_TH = 2,
    localparam int AW       = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [AW:0]       count,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [AW:0] c_depth  = (AW+1)'(DEPTH);
    localparam logic [AW:0] c_afull  = (AW+1)'(AFULL_TH);
    localparam logic [AW:0] c_aempty = (AW+1)'(AEMPTY_TH);
    localparam logic [AW:0] c_one    = (AW+1)'(1);

    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q, count_d;
    logic              overflow_q, underflow_q;
    logic              w_wr_acc, w_rd_acc;
    logic [DATA_W-1:0] w_rd_word;

    assign empty        = (count_q == '0);
    assign full         = (count_q == c_depth);
    assign almost_full  = (count_q >= c_afull);
    assign almost_empty = (count_q <= c_aempty);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    // A read frees a slot in the same edge, so a full FIFO can still accept a write.
    assign w_rd_acc = rd_en & ~empty;
    assign w_wr_acc = wr_en & (~full | w_rd_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_wr_acc) begin
            wr_ptr_d = wr_ptr_q + c_one;
        end
        if (w_rd_acc) begin
            rd_ptr_d = rd_ptr_q + c_one;
        end
        case ({w_wr_acc, w_rd_acc})
            2'b10:   count_d = count_q + c_one;
            2'b01:   count_d = count_q - c_one;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= wr_en & ~w_wr_acc;
            underflow_q <= rd_en & ~w_rd_acc;
        end
    end

    fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk       (clk),
        .wr_en_i   (w_wr_acc),
        .wr_idx_i  (wr_ptr_q[AW-1:0]),
        .wr_data_i (data_in),
        .rd_idx_i  (rd_ptr_q[AW-1:0]),
        .rd_data_o (w_rd_word)
    );

`ifdef FIFO_FWFT_EN
    // Head word is shown directly; zero while empty keeps reset output at 0.
    assign data_out = empty ? '0 : w_rd_word;
    assign rd_valid = ~empty;
`else
    logic [DATA_W-1:0] data_out_q;
    logic              rd_valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= w_rd_acc;
            if (w_rd_acc) begin
                data_out_q <= w_rd_word;
            end
        end
    end

    assign data_out = data_out_q;
    assign rd_valid = rd_valid_q;
`endif

endmodule : sync_fifo
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_sync_fifo
// Purpose  : Self-checking bench for sync_fifo against a queue-based model.
// Revision : 1.0
// ============================================================================
module tb_sync_fifo;

    localparam int DATA_W    = 16;
    localparam int DEPTH     = 8;
    localparam int AFULL_TH  = 6;
    localparam int AEMPTY_TH = 2;

    logic              clk;
    logic              rst;
    logic              wr_en;
    logic [DATA_W-1:0] data_in;
    logic              rd_en;
    logic [DATA_W-1:0] data_out;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic              almost_full;
    logic              almost_empty;
    logic [3:0]        count;
    logic              overflow;
    logic              underflow;

    int n_cmp;
    int n_err;

    logic [DATA_W-1:0] q_m [$];
    logic              exp_ovf;
    logic              exp_unf;
`ifndef FIFO_FWFT_EN
    logic [DATA_W-1:0] exp_dout;
    logic              exp_valid;
`endif

    sync_fifo #(
        .DATA_W    (DATA_W),
        .DEPTH     (DEPTH),
        .AFULL_TH  (AFULL_TH),
        .AEMPTY_TH (AEMPTY_TH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .data_in      (data_in),
        .rd_en        (rd_en),
        .data_out     (data_out),
        .rd_valid     (rd_valid),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (got !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q_m.delete();
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
`ifndef FIFO_FWFT_EN
        exp_dout  = '0;
        exp_valid = 1'b0;
`endif
    endtask

    // Queue model: reads are refused when empty, writes when full unless a read frees a slot.
    task automatic model_step(input logic wr, input logic [DATA_W-1:0] din, input logic rd);
        bit was_empty;
        bit was_full;
        bit rd_ok;
        bit wr_ok;
        was_empty = (q_m.size() == 0);
        was_full  = (q_m.size() == DEPTH);
        rd_ok     = rd && !was_empty;
        wr_ok     = wr && (!was_full || rd_ok);
`ifndef FIFO_FWFT_EN
        exp_valid = rd_ok;
        if (rd_ok) exp_dout = q_m[0];
`endif
        if (rd_ok) void'(q_m.pop_front());
        if (wr_ok) q_m.push_back(din);
        exp_ovf = wr && !wr_ok;
        exp_unf = rd && !rd_ok;
    endtask

    task automatic check_outputs(input string ph);
        int n;
        n = q_m.size();
        chk({ph, ".count"},  32'(count),        32'(n));
        chk({ph, ".full"},   32'(full),         32'(n == DEPTH));
        chk({ph, ".empty"},  32'(empty),        32'(n == 0));
        chk({ph, ".afull"},  32'(almost_full),  32'(n >= AFULL_TH));
        chk({ph, ".aempty"}, 32'(almost_empty), 32'(n <= AEMPTY_TH));
        chk({ph, ".ovf"},    32'(overflow),     32'(exp_ovf));
        chk({ph, ".unf"},    32'(underflow),    32'(exp_unf));
`ifdef FIFO_FWFT_EN
        chk({ph, ".valid"},  32'(rd_valid),     32'(n != 0));
        if (n != 0) chk({ph, ".dout"}, 32'(data_out), 32'(q_m[0]));
`else
        chk({ph, ".valid"},  32'(rd_valid),     32'(exp_valid));
        chk({ph, ".dout"},   32'(data_out),     32'(exp_dout));
`endif
    endtask

    task automatic cycle(input string ph, input logic wr, input logic [DATA_W-1:0] din,
                         input logic rd);
        wr_en   = wr;
        data_in = din;
        rd_en   = rd;
        @(posedge clk);
        model_step(wr, din, rd);
        #1;
        check_outputs(ph);
    endtask

    task automatic check_reset_state(input string ph);
        chk({ph, ".count"},  32'(count),        32'd0);
        chk({ph, ".full"},   32'(full),         32'd0);
        chk({ph, ".empty"},  32'(empty),        32'd1);
        chk({ph, ".afull"},  32'(almost_full),  32'd0);
        chk({ph, ".aempty"}, 32'(almost_empty), 32'd1);
        chk({ph, ".ovf"},    32'(overflow),     32'd0);
        chk({ph, ".unf"},    32'(underflow),    32'd0);
        chk({ph, ".valid"},  32'(rd_valid),     32'd0);
        chk({ph, ".dout"},   32'(data_out),     32'd0);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst     = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        data_in = '0;
        model_reset();

        // Reset and idle.
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("rst");
        rst = 1'b1;
        repeat (2) cycle("idle", 1'b0, '0, 1'b0);

        // Fill with 1..8, then one write too many, then drain in order.
        for (int i = 1; i <= DEPTH; i++) cycle("fill", 1'b1, DATA_W'(i), 1'b0);
        chk("fill.full_now", 32'(full), 32'd1);
        cycle("ovf", 1'b1, 16'h0009, 1'b0);
        cycle("ovf_clr", 1'b0, '0, 1'b0);
        for (int i = 1; i <= DEPTH; i++) cycle("drain", 1'b0, '0, 1'b1);
        cycle("drain_end", 1'b0, '0, 1'b0);

        // Empty edge cases.
        cycle("unf", 1'b0, '0, 1'b1);
        cycle("unf_clr", 1'b0, '0, 1'b0);
        cycle("wr_rd_empty", 1'b1, 16'h1234, 1'b1);
        chk("wr_rd_empty.count1", 32'(count), 32'd1);
        cycle("pop1", 1'b0, '0, 1'b1);

        // Full with simultaneous read/write across pointer wrap.
        for (int i = 0; i < DEPTH; i++) cycle("refill", 1'b1, DATA_W'(16'h0100 + i), 1'b0);
        for (int i = 0; i < 20; i++) cycle("full_rw", 1'b1, DATA_W'(16'h0200 + i), 1'b1);
        for (int i = 0; i < DEPTH; i++) cycle("full_drain", 1'b0, '0, 1'b1);
        cycle("full_drain_end", 1'b0, '0, 1'b0);

        // Mid-burst asynchronous reset.
        for (int i = 0; i < 5; i++) cycle("pre_rst", 1'b1, DATA_W'(16'h0C00 + i), 1'b0);
        wr_en   = 1'b1;
        data_in = 16'h0DDD;
        #3;
        rst = 1'b0;
        #1;
        check_reset_state("async_rst");
        @(posedge clk);
        #1;
        check_reset_state("rst_hold");
        wr_en = 1'b0;
        rst   = 1'b1;
        model_reset();
        cycle("post_rst_wr", 1'b1, 16'h5A5A, 1'b0);
`ifdef FIFO_FWFT_EN
        chk("post_rst.fwft_dout", 32'(data_out), 32'h5A5A);
`endif
        cycle("post_rst_rd", 1'b0, '0, 1'b1);
`ifndef FIFO_FWFT_EN
        chk("post_rst.dout", 32'(data_out), 32'h5A5A);
`endif
        cycle("post_rst_idle", 1'b0, '0, 1'b0);

`ifdef FIFO_FWFT_EN
        cycle("fwft_wr", 1'b1, 16'hABCD, 1'b0);
        chk("fwft.dout",  32'(data_out), 32'hABCD);
        chk("fwft.valid", 32'(rd_valid), 32'd1);
        cycle("fwft_pop", 1'b0, '0, 1'b1);
        chk("fwft.empty", 32'(empty), 32'd1);
`endif

        // Randomised traffic: write-heavy, then read-heavy, then balanced.
        for (int i = 0; i < 600; i++) begin
            int wp;
            int rp;
            wp = (i < 200) ? 70 : (i < 400) ? 30 : 50;
            rp = (i < 200) ? 30 : (i < 400) ? 70 : 50;
            cycle("rand", ($urandom_range(0, 99) < wp), DATA_W'($urandom),
                  ($urandom_range(0, 99) < rp));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete (compared=%0d)", n_cmp);
        $fatal(1, "timeout");
    end

endmodule : tb_sync_fifo
`default_nettype wire

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Parametrised single-clock FIFO; successor to the fixed 8x16 memory buffer.
- Adds configurable width and depth, full/empty and almost-full/almost-empty flags, occupancy count, overflow/underflow protection and error pulses, and a registered read path with a valid strobe.
- Sits between producer and consumer blocks in the same clock domain.

Parameters:
- DATA_W, 16, data word width in bits (>=1).
- DEPTH, 8, number of entries; power of two, >=2.
- AFULL_TH, 6, almost_full asserts when count >= AFULL_TH (1..DEPTH).
- AEMPTY_TH, 2, almost_empty asserts when count <= AEMPTY_TH (0..DEPTH-1).

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  asynchronous active-low reset.
- wr_en  input  1  write request.
- data_in  input  DATA_W  write data.
- rd_en  input  1  read request.
- data_out  output  DATA_W  read data (registered).
- rd_valid  output  1  data_out holds a newly read word this cycle.
- full  output  1  count == DEPTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= AFULL_TH.
- almost_empty  output  1  count <= AEMPTY_TH.
- count  output  AW+1  occupancy 0..DEPTH, AW = clog2(DEPTH).
- overflow  output  1  one-cycle pulse: write rejected.
- underflow  output  1  one-cycle pulse: read rejected.

Behaviour:
- Reset: clk and rst as already decided (one clock; asynchronous active-low reset). While rst=0: pointers=0, count=0, data_out=0, rd_valid=0, overflow=0, underflow=0, empty=1, full=0, almost_empty=1, almost_full=0. Storage contents are not reset. A reset mid-operation discards all stored data immediately.
- Pointers: AW+1 bits (extra wrap bit). Write and read pointers increment by 1 per accepted op and wrap modulo 2*DEPTH. The storage index is the low AW bits.
- Write accept: wr_acc = wr_en & (!full | rd_acc). An accepted write stores data_in at the write index on the clock edge.
- Read accept: rd_acc = rd_en & !empty.
  - Read-while-empty is always rejected, even with a simultaneous write; that write is accepted.
  - Read latency is 1 cycle: the word at the read index is registered into data_out, and rd_valid=1 on the following cycle.
  - data_out holds its last value when no read is accepted; rd_valid=0.
- Simultaneous accepted read and write: count unchanged. When full with rd_en=1, both ops are accepted and full stays 1.
- count: +1 on write only, -1 on read only. It never exceeds DEPTH and never goes below 0.
- Flags: all derived from the registered count or pointers; they update on the edge that changes occupancy, with no combinational path from wr_en/rd_en.
- Error pulses:
  - overflow=1 for exactly one cycle after an edge where wr_en=1 and the write was rejected.
  - underflow likewise for a rejected rd_en.
  - A rejected op never changes pointers, count or storage.

Optional Feature:
- Macro FIFO_FWFT_EN selects first-word-fall-through mode.
- Defined:
  - data_out combinationally presents the word at the read index whenever !empty.
  - rd_valid = !empty.
  - rd_en acts as acknowledge/pop; latency from first write to visible data is 1 cycle.
  - Reset and flag behaviour unchanged.
- Undefined: registered 1-cycle read as above.

Decomposition:
- Package fifo_pkg: clog2 function, DEFAULT_DATA_W=16, DEFAULT_DEPTH=8 constants.
- Sub-module fifo_mem: simple dual-port array with parameters DATA_W and DEPTH; sync write port; async read port with index input. Used by sync_fifo for storage only.
- Pointer, count and flag logic stay in sync_fifo.

Test Plan:
- Reset then idle -> empty=1, full=0, count=0, almost_empty=1, data_out=0, no pulses.
- Write 0x0001..0x0008 (DEPTH=8) back-to-back -> full=1, count=8; almost_full first rises when count reaches 6. A 9th write -> overflow pulse for 1 cycle, count stays 8. Then 8 reads -> data_out 0x0001..0x0008 in order, each one cycle after rd_en, with rd_valid=1.
- Empty FIFO, rd_en=1 -> underflow pulse, rd_valid=0, count=0. Simultaneous wr_en=1 rd_en=1 on empty -> write accepted, read rejected, count=1.
- Full FIFO, wr_en=1 rd_en=1 for 20 cycles with incrementing data -> full held, count=8, no overflow, output stream matches input order across pointer wrap.
- Fill to 5 entries, drop rst mid-burst -> all outputs at reset values asynchronously. After release, a single write and read returns the new word, not stale data.
- FIFO_FWFT_EN defined: write 0xABCD to empty FIFO -> next cycle data_out=0xABCD and rd_valid=1 without rd_en. A pop then gives empty=1.
